// File: rtl/fft_pkg.sv
// fft_pkg: shared helpers for the radix-2 FFT butterfly datapath.
// Complex words are packed {real, imag}; helpers work on a wide signed
// carrier and callers size-cast results down to their real widths.
// FFT_BFLY_SAT_EN: when defined, out-of-range results clamp; otherwise wrap.
package fft_pkg;
  localparam int MAX_W = 64;
  typedef logic signed [MAX_W-1:0] wide_t;

  // Twiddle Q2.(TW_SZ-2) unity for the default 8-bit twiddle width
  localparam int TW_SZ_DEF = 8;
  localparam int TW_ONE    = 1 << (TW_SZ_DEF - 2);

  // Sign-extend the low m bits of v
  function automatic wide_t sext(input wide_t v, input int m);
    return (v <<< (MAX_W - m)) >>> (MAX_W - m);
  endfunction

  // Real half of a packed complex word with m-bit components
  function automatic wide_t cpx_re(input wide_t w, input int m);
    return sext(w >>> m, m);
  endfunction

  // Imag half of a packed complex word with m-bit components
  function automatic wide_t cpx_im(input wide_t w, input int m);
    return sext(w, m);
  endfunction

  // Pack two m-bit components back into {real, imag}
  function automatic wide_t cpx_pack(input wide_t re, input wide_t im, input int m);
    wide_t mask;
    mask = (wide_t'(1) <<< m) - wide_t'(1);
    return ((re & mask) <<< m) | (im & mask);
  endfunction

  // Reduce v to signed m bits, flagging any out-of-range value
  function automatic wide_t fit(input wide_t v, input int m, output logic ovf);
    wide_t hi, lo, r;
    hi  = (wide_t'(1) <<< (m - 1)) - wide_t'(1);
    lo  = -(wide_t'(1) <<< (m - 1));
    ovf = (v > hi) || (v < lo);
`ifdef FFT_BFLY_SAT_EN
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
`else
    r = sext(v, m);
`endif
    return r;
  endfunction
endpackage

// File: rtl/fft_cmult.sv
// fft_cmult: combinational complex multiply D*W with twiddle rescale.
// Products are exact at M+TW_SZ+1 bits, then floor-shifted by TW_SZ-2 and
// reduced to M bits (clamp or wrap depending on FFT_BFLY_SAT_EN).
module fft_cmult
  import fft_pkg::*;
#(
  parameter int M     = 8,
  parameter int TW_SZ = 8
) (
  input  logic [2*M-1:0]     d,
  input  logic [2*TW_SZ-1:0] w,
  output logic [2*M-1:0]     p,
  output logic               ovf
);
  localparam int PW = M + TW_SZ + 1;

  logic signed [PW-1:0] dr, di, wr, wi, pr, pi;
  wide_t fr, fi;
  logic  ov_r, ov_i;

  // Full-precision rotate, rescale out of Q format, reduce to M bits
  always_comb begin
    ov_r = 1'b0;
    ov_i = 1'b0;
    dr   = PW'(cpx_re(wide_t'(d), M));
    di   = PW'(cpx_im(wide_t'(d), M));
    wr   = PW'(cpx_re(wide_t'(w), TW_SZ));
    wi   = PW'(cpx_im(wide_t'(w), TW_SZ));
    pr   = dr * wr - di * wi;
    pi   = dr * wi + di * wr;
    fr   = fit(wide_t'(pr >>> (TW_SZ - 2)), M, ov_r);
    fi   = fit(wide_t'(pi >>> (TW_SZ - 2)), M, ov_i);
    p    = (2*M)'(cpx_pack(fr, fi, M));
    ovf  = ov_r | ov_i;
  end
endmodule

// File: rtl/fft_bfly_r2.sv
// fft_bfly_r2: two-stage radix-2 DIF butterfly, A+B and (A-B)*W.
// Stage 1 add/sub (optional /2), stage 2 twiddle multiply. Valid/ready
// handshake with a 2-entry pipeline; stalled outputs hold.
// FFT_BFLY_SAT_EN: when defined, overflowing components clamp; else wrap.
module fft_bfly_r2
  import fft_pkg::*;
#(
  parameter int WORD_SZ = 16,
  parameter int TW_SZ   = 8,
  parameter int TAG_SZ  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WORD_SZ-1:0]   i_A,
  input  logic [WORD_SZ-1:0]   i_B,
  input  logic [2*TW_SZ-1:0]   i_W,
  input  logic                 i_scale,
  input  logic [TAG_SZ-1:0]    i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WORD_SZ-1:0]   o_A,
  output logic [WORD_SZ-1:0]   o_B,
  output logic [TAG_SZ-1:0]    o_tag,
  output logic                 o_ovf
);
  localparam int M      = WORD_SZ / 2;
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic s1_adv, s2_adv, accept;

  // Stage registers
  logic [WORD_SZ-1:0] s1_s, s1_d, s2_a, s2_b;
  logic [2*TW_SZ-1:0] s1_w;
  logic [TAG_SZ-1:0]  s1_tag, s2_tag;
  logic               s1_ovf, s2_ovf;

  // Stage-1 combinational results
  wide_t ar, ai, br, bi, sr, si, dr, di;
  logic  ov_sr, ov_si, ov_dr, ov_di;
  logic [WORD_SZ-1:0] s_nxt, d_nxt;

  // Stage-2 multiplier results
  logic [WORD_SZ-1:0] cm_p;
  logic               cm_ovf;

  // A stage may load when it is empty or its contents move on this edge
  assign s2_adv  = !vld_pipe[2] || i_ready;
  assign s1_adv  = !vld_pipe[1] || s2_adv;
  assign o_ready = s1_adv;
  assign accept  = i_valid && s1_adv;

  // Add/sub at M+1 bits; scaling halves by floor shift and cannot overflow
  always_comb begin
    ov_sr = 1'b0;
    ov_si = 1'b0;
    ov_dr = 1'b0;
    ov_di = 1'b0;
    ar = cpx_re(wide_t'(i_A), M);
    ai = cpx_im(wide_t'(i_A), M);
    br = cpx_re(wide_t'(i_B), M);
    bi = cpx_im(wide_t'(i_B), M);
    if (i_scale) begin
      sr = (ar + br) >>> 1;
      si = (ai + bi) >>> 1;
      dr = (ar - br) >>> 1;
      di = (ai - bi) >>> 1;
    end else begin
      sr = fit(ar + br, M, ov_sr);
      si = fit(ai + bi, M, ov_si);
      dr = fit(ar - br, M, ov_dr);
      di = fit(ai - bi, M, ov_di);
    end
    s_nxt = WORD_SZ'(cpx_pack(sr, si, M));
    d_nxt = WORD_SZ'(cpx_pack(dr, di, M));
  end

  fft_cmult #(
    .M     (M),
    .TW_SZ (TW_SZ)
  ) u_cmult (
    .d   (s1_d),
    .w   (s1_w),
    .p   (cm_p),
    .ovf (cm_ovf)
  );

  // Valid shift register, each stage moving only when allowed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= i_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // Stage-1 data capture on accepted input
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_s   <= '0;
      s1_d   <= '0;
      s1_w   <= '0;
      s1_tag <= '0;
      s1_ovf <= 1'b0;
    end else if (accept) begin
      s1_s   <= s_nxt;
      s1_d   <= d_nxt;
      s1_w   <= i_W;
      s1_tag <= i_tag;
      s1_ovf <= ov_sr | ov_si | ov_dr | ov_di;
    end
  end

  // Stage-2 data capture; holds while the consumer stalls
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_a   <= '0;
      s2_b   <= '0;
      s2_tag <= '0;
      s2_ovf <= 1'b0;
    end else if (s2_adv && vld_pipe[1]) begin
      s2_a   <= s1_s;
      s2_b   <= cm_p;
      s2_tag <= s1_tag;
      s2_ovf <= s1_ovf | cm_ovf;
    end
  end

  assign o_valid = vld_pipe[2];
  assign o_A     = s2_a;
  assign o_B     = s2_b;
  assign o_tag   = s2_tag;
  assign o_ovf   = s2_ovf;
endmodule

// File: tb/tb_fft_bfly_r2.sv
// tb_fft_bfly_r2: directed checks of the radix-2 butterfly (WORD_SZ=16, TW_SZ=8).
// Expected values are hand-computed; FFT_BFLY_SAT_EN selects clamp vs wrap.
module tb_fft_bfly_r2;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b1, i_scale = 1'b0;
  logic [15:0] i_A = '0, i_B = '0, i_W = '0;
  logic [3:0]  i_tag = '0;
  logic        o_ready, o_valid, o_ovf;
  logic [15:0] o_A, o_B;
  logic [3:0]  o_tag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a, b, w;
    logic        sc;
    logic [15:0] ea, eb;
    logic        eo;
  } vec_t;

  fft_bfly_r2 #(.WORD_SZ(16), .TW_SZ(8), .TAG_SZ(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_A(i_A), .i_B(i_B), .i_W(i_W), .i_scale(i_scale), .i_tag(i_tag),
    .o_valid(o_valid), .i_ready(i_ready), .o_A(o_A), .o_B(o_B),
    .o_tag(o_tag), .o_ovf(o_ovf)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] cx(input int re, input int im);
    return {8'(re), 8'(im)};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_A !== 16'h0 || o_B !== 16'h0) begin errors++; $display("FAIL reset_data got A=%h B=%h exp 0", o_A, o_B); end
    checks++; if (o_tag !== 4'h0 || o_ovf !== 1'b0) begin errors++; $display("FAIL reset_tag_ovf got tag=%h ovf=%b exp 0", o_tag, o_ovf); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin errors++; $display("FAIL post_reset got ready=%b valid=%b exp 1/0", o_ready, o_valid); end
  endtask

  task automatic test_arith();
    vec_t v[4];
    v[0] = '{cx(3,1),  cx(1,2),  cx(64,0),  1'b0, cx(4,3),  cx(2,-1),  1'b0};
    v[1] = '{cx(3,1),  cx(1,2),  cx(0,-64), 1'b0, cx(4,3),  cx(-1,-2), 1'b0};
    v[2] = '{cx(3,-3), cx(0,0),  cx(32,0),  1'b1, cx(1,-2), cx(0,-1),  1'b0};
    v[3] = '{cx(-5,7), cx(2,-3), cx(-64,0), 1'b0, cx(-3,4), cx(7,-10), 1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1; i_A = v[k].a; i_B = v[k].b; i_W = v[k].w;
      i_scale = v[k].sc; i_tag = 4'(k);
      @(negedge i_clk);
      i_valid = 1'b0;
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL arith%0d_early got valid=%b exp=0", k, o_valid); end
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_A !== v[k].ea || o_B !== v[k].eb || o_ovf !== v[k].eo || o_tag !== 4'(k)) begin
        errors++;
        $display("FAIL arith%0d got v=%b A=%h B=%h ovf=%b tag=%0d exp A=%h B=%h ovf=%b tag=%0d",
                 k, o_valid, o_A, o_B, o_ovf, o_tag, v[k].ea, v[k].eb, v[k].eo, k);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[4];
`ifdef FFT_BFLY_SAT_EN
    v[0] = '{cx(100,0),   cx(100,0),  cx(64,0),  1'b0, cx(127,0),   cx(0,0),    1'b1};
    v[2] = '{cx(-128,-128), cx(0,0),  cx(64,64), 1'b0, cx(-128,-128), cx(0,-128), 1'b1};
    v[3] = '{cx(100,0),   cx(-100,0), cx(64,0),  1'b0, cx(0,0),     cx(127,0),  1'b1};
`else
    v[0] = '{cx(100,0),   cx(100,0),  cx(64,0),  1'b0, cx(-56,0),   cx(0,0),    1'b1};
    v[2] = '{cx(-128,-128), cx(0,0),  cx(64,64), 1'b0, cx(-128,-128), cx(0,0),   1'b1};
    v[3] = '{cx(100,0),   cx(-100,0), cx(64,0),  1'b0, cx(0,0),     cx(-56,0),  1'b1};
`endif
    v[1] = '{cx(100,0),   cx(100,0),  cx(64,0),  1'b1, cx(100,0),   cx(0,0),    1'b0};
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_ready = 1'b1; i_valid = 1'b1; i_A = v[k].a; i_B = v[k].b; i_W = v[k].w;
      i_scale = v[k].sc; i_tag = 4'(k + 4);
      @(negedge i_clk);
      i_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_A !== v[k].ea || o_B !== v[k].eb || o_ovf !== v[k].eo) begin
        errors++;
        $display("FAIL ovf%0d got v=%b A=%h B=%h ovf=%b exp A=%h B=%h ovf=%b",
                 k, o_valid, o_A, o_B, o_ovf, v[k].ea, v[k].eb, v[k].eo);
      end
    end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, nhold = 0;
    bit dropped = 0, hold = 0;
    logic [15:0] pa = '0, pb = '0;
    logic [3:0]  pt = '0;
    logic        po = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge i_clk);
      if (hold) begin
        nhold++;
        checks++;
        if (o_valid !== 1'b1 || o_A !== pa || o_B !== pb || o_tag !== pt || o_ovf !== po) begin
          errors++;
          $display("FAIL stall_hold got v=%b A=%h B=%h tag=%0d exp A=%h B=%h tag=%0d", o_valid, o_A, o_B, o_tag, pa, pb, pt);
        end
      end
      i_ready = !(cyc >= 3 && cyc < 6);
      i_valid = (sent < 6);
      i_A = cx(sent + 1, sent); i_B = cx(1, 0); i_W = cx(64, 0); i_scale = 1'b0; i_tag = 4'(sent);
      #1;
      if (!o_ready) dropped = 1;
      if (o_valid && i_ready) begin
        checks++;
        if (o_tag !== 4'(got) || o_A !== cx(got + 2, got) || o_B !== cx(got, got) || o_ovf !== 1'b0) begin
          errors++;
          $display("FAIL stream_out got tag=%0d A=%h B=%h exp tag=%0d A=%h B=%h", o_tag, o_A, o_B, got, cx(got + 2, got), cx(got, got));
        end
        got++;
      end
      hold = o_valid && !i_ready;
      pa = o_A; pb = o_B; pt = o_tag; po = o_ovf;
      if (i_valid && o_ready) sent++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    checks++; if (got != 6) begin errors++; $display("FAIL stall_count got=%0d exp=6", got); end
    checks++; if (!dropped || nhold != 3) begin errors++; $display("FAIL stall_backpressure got drop=%0d holds=%0d exp 1/3", dropped, nhold); end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup got valid=%b exp=0", o_valid); end
  endtask

  task automatic test_reset_midstream();
    @(negedge i_clk);
    i_ready = 1'b0; i_valid = 1'b1; i_A = cx(10, 0); i_B = cx(0, 0); i_W = cx(64, 0); i_scale = 1'b0; i_tag = 4'd7;
    @(negedge i_clk);
    i_tag = 4'd8;
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL midrst_full got valid=%b ready=%b exp 1/0", o_valid, o_ready); end
    i_rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL midrst_flags got valid=%b ready=%b exp 0/1", o_valid, o_ready); end
    checks++; if (o_A !== 16'h0 || o_B !== 16'h0 || o_tag !== 4'h0 || o_ovf !== 1'b0) begin errors++; $display("FAIL midrst_data got A=%h B=%h tag=%0d ovf=%b exp 0", o_A, o_B, o_tag, o_ovf); end
    @(negedge i_clk);
    i_rst = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
    i_A = cx(3, 1); i_B = cx(1, 2); i_W = cx(64, 0); i_tag = 4'd9;
    @(negedge i_clk);
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got valid=%b exp=0", o_valid); end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b1 || o_tag !== 4'd9 || o_A !== cx(4, 3) || o_B !== cx(2, -1)) begin
      errors++;
      $display("FAIL midrst_next got v=%b tag=%0d A=%h B=%h exp tag=9 A=%h B=%h", o_valid, o_tag, o_A, o_B, cx(4, 3), cx(2, -1));
    end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_drain got valid=%b exp=0", o_valid); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_valid = (i < 8);
      i_A = cx(i, 1); i_B = cx(i, 0); i_W = cx(64, 0); i_scale = 1'b0; i_tag = 4'(i);
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, o_ready); end
      if (i >= 2) begin
        checks++;
        if (o_valid !== 1'b1 || o_tag !== 4'(i - 2) || o_A !== cx(2 * (i - 2), 1) || o_B !== cx(0, 1)) begin
          errors++;
          $display("FAIL b2b_out cyc=%0d got v=%b tag=%0d A=%h B=%h exp tag=%0d A=%h B=%h",
                   i, o_valid, o_tag, o_A, o_B, i - 2, cx(2 * (i - 2), 1), cx(0, 1));
        end
      end
    end
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_overflow();
    test_stall();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
